// File: rtl/lpgbt_uplink_capture.sv
// lpGBT uplink capture buffer: one selected channel feeds a frame FIFO that software drains
// over AXI4-Lite, while per-channel FEC-correction counters run regardless of capture state.
module lpgbt_uplink_capture #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 11,
    parameter int NUM_CH             = 2,
    parameter int FRAME_WIDTH        = 234,
    parameter int DEPTH              = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [NUM_CH-1:0]               frame_valid_i,
    input  logic [NUM_CH*FRAME_WIDTH-1:0]   frame_data_i,
    input  logic [NUM_CH-1:0]               uplinkrdy_i,
    input  logic [NUM_CH-1:0]               fec_i,
    output logic                            irq_o,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);
    localparam int NW = (FRAME_WIDTH + 31) / 32;
    localparam int AW = $clog2(DEPTH);
    localparam int WA = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [WA-1:0] A_CTRL   = WA'(0);
    localparam logic [WA-1:0] A_STATUS = WA'(1);
    localparam logic [WA-1:0] A_POP    = WA'(2);
    localparam logic [WA-1:0] A_FEC    = WA'(16);
    localparam logic [WA-1:0] A_HEAD   = WA'(64);
    localparam logic [AW:0]   LVL_LAST = (AW+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0, ST_ARMED = 2'd1, ST_CAPTURE = 2'd2, ST_DONE = 2'd3
    } state_t;

    state_t                  state_r, state_nx_s;
    logic                    aw_rdy_r, bvalid_r, ar_rdy_r, rvalid_r;
    logic [31:0]             rdata_r, rd_data_s;
    logic                    mode_r, skip_fec_r, act_mode_r, act_skip_r;
    logic [2:0]              ch_sel_r, act_ch_r;
    logic [FRAME_WIDTH-1:0]  mem_r [DEPTH];
    logic [AW-1:0]           wr_ptr_r, rd_ptr_r;
    logic [AW:0]             level_r;
    logic                    ovf_r, lost_r, irq_r, ovf_nx_s, lost_nx_s, lost_set_s;
    logic [31:0]             fec_cnt_r [NUM_CH];
    logic [WA-1:0]           wr_word_s, rd_word_s;
    logic                    wr_s, rd_s, ctrl_wr_s, arm_s, stop_s, flush_s, pop_s, arm_take_s;
    logic                    sel_valid_s, sel_fec_s, sel_rdy_s, empty_s, full_s;
    logic                    push_req_s, push_ok_s, drop_s, fill_s;
    logic [FRAME_WIDTH-1:0]  sel_data_s;
    logic [NW*32-1:0]        head_pad_s;
    logic                    unused_s;

    assign unused_s = ^{S_AXI_WSTRB, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WDATA,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_word_s  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_word_s  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_s       = aw_rdy_r & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_s       = ar_rdy_r & S_AXI_ARVALID;
    assign ctrl_wr_s  = wr_s & (wr_word_s == A_CTRL);
    assign arm_s      = ctrl_wr_s & S_AXI_WDATA[0];
    assign stop_s     = ctrl_wr_s & S_AXI_WDATA[2];
    assign flush_s    = ctrl_wr_s & S_AXI_WDATA[3];
    assign arm_take_s = arm_s & ~stop_s & ((state_r == ST_IDLE) | (state_r == ST_DONE));
    assign empty_s    = (level_r == '0);
    assign full_s     = level_r[AW];
    assign pop_s      = wr_s & (wr_word_s == A_POP) & ~empty_s;

    // Route the latched capture channel onto single-bit / single-frame selections
    always_comb begin
        sel_valid_s = 1'b0;
        sel_fec_s   = 1'b0;
        sel_rdy_s   = 1'b0;
        sel_data_s  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sel_valid_s = sel_valid_s | ((act_ch_r == 3'(c)) & frame_valid_i[c]);
            sel_fec_s   = sel_fec_s   | ((act_ch_r == 3'(c)) & fec_i[c]);
            sel_rdy_s   = sel_rdy_s   | ((act_ch_r == 3'(c)) & uplinkrdy_i[c]);
            sel_data_s  = sel_data_s  | ({FRAME_WIDTH{act_ch_r == 3'(c)}}
                                         & frame_data_i[c*FRAME_WIDTH +: FRAME_WIDTH]);
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts; FLUSH drops the frame
    assign push_req_s = (state_r == ST_CAPTURE) & sel_valid_s & ~(act_skip_r & sel_fec_s);
    assign push_ok_s  = push_req_s & (~full_s | pop_s) & ~flush_s;
    assign drop_s     = push_req_s & full_s & ~pop_s & ~flush_s;
    assign fill_s     = push_ok_s & ~pop_s & (level_r == LVL_LAST);

    // Capture FSM next state; STOP overrides everything, including ARM in the same write
    always_comb begin
        state_nx_s = state_r;
        lost_set_s = 1'b0;
        if (stop_s) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:    state_nx_s = arm_s ? ST_ARMED : ST_IDLE;
                ST_ARMED:   state_nx_s = sel_rdy_s ? ST_CAPTURE : ST_ARMED;
                ST_CAPTURE: begin
                    if (!sel_rdy_s) begin
                        state_nx_s = ST_ARMED;
                        lost_set_s = 1'b1;
                    end else if (!act_mode_r && (drop_s || fill_s)) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_CAPTURE;
                    end
                end
                ST_DONE:    state_nx_s = arm_s ? ST_ARMED : ST_DONE;
                default:    state_nx_s = ST_IDLE;
            endcase
        end
        ovf_nx_s  = flush_s ? 1'b0 : (ovf_r | (drop_s & act_mode_r));
        lost_nx_s = flush_s ? 1'b0 : (lost_r | lost_set_s);
    end

    // Control/state registers, sticky flags and the interrupt line
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_r    <= ST_IDLE;
            mode_r     <= 1'b0;
            skip_fec_r <= 1'b0;
            ch_sel_r   <= 3'd0;
            act_mode_r <= 1'b0;
            act_skip_r <= 1'b0;
            act_ch_r   <= 3'd0;
            ovf_r      <= 1'b0;
            lost_r     <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ovf_r   <= ovf_nx_s;
            lost_r  <= lost_nx_s;
            irq_r   <= (state_nx_s == ST_DONE) | ovf_nx_s;
            if (ctrl_wr_s) begin
                mode_r     <= S_AXI_WDATA[1];
                ch_sel_r   <= S_AXI_WDATA[10:8];
                skip_fec_r <= S_AXI_WDATA[16];
            end
            if (arm_take_s) begin
                act_mode_r <= S_AXI_WDATA[1];
                act_ch_r   <= S_AXI_WDATA[10:8];
                act_skip_r <= S_AXI_WDATA[16];
            end
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (flush_s) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_r + AW'(push_ok_s);
            rd_ptr_r <= rd_ptr_r + AW'(pop_s);
            case ({push_ok_s, pop_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Frame storage
    always_ff @(posedge S_AXI_ACLK) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= sel_data_s;
    end

    // Saturating FEC counters; a write to the counter clears it
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int c = 0; c < NUM_CH; c++) fec_cnt_r[c] <= 32'd0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_s && (wr_word_s == A_FEC + WA'(c)))
                    fec_cnt_r[c] <= 32'd0;
                else if (frame_valid_i[c] && fec_i[c] && (fec_cnt_r[c] != 32'hFFFF_FFFF))
                    fec_cnt_r[c] <= fec_cnt_r[c] + 32'd1;
            end
        end
    end

    // Read data mux; HEAD words come from the pre-pop head
    always_comb begin
        head_pad_s = '0;
        head_pad_s[FRAME_WIDTH-1:0] = empty_s ? '0 : mem_r[rd_ptr_r];
        rd_data_s = 32'd0;
        case (rd_word_s)
            A_CTRL:   rd_data_s = {15'd0, skip_fec_r, 5'd0, ch_sel_r, 6'd0, mode_r, 1'b0};
            A_STATUS: rd_data_s = {8'(uplinkrdy_i), 4'd0, lost_r, ovf_r, full_s, empty_s,
                                   8'(level_r), 6'd0, state_r};
            default: begin
                for (int c = 0; c < NUM_CH; c++)
                    rd_data_s = rd_data_s | ((rd_word_s == A_FEC + WA'(c)) ? fec_cnt_r[c] : 32'd0);
                for (int k = 0; k < NW; k++)
                    rd_data_s = rd_data_s | ((rd_word_s == A_HEAD + WA'(k)) ? head_pad_s[k*32 +: 32] : 32'd0);
            end
        endcase
    end

    // AXI4-Lite handshake registers
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_rdy_r <= 1'b0;
            bvalid_r <= 1'b0;
            ar_rdy_r <= 1'b0;
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
        end else begin
            aw_rdy_r <= ~aw_rdy_r & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_r;
            ar_rdy_r <= ~ar_rdy_r & S_AXI_ARVALID & ~rvalid_r;
            if (wr_s)              bvalid_r <= 1'b1;
            else if (S_AXI_BREADY) bvalid_r <= 1'b0;
            if (rd_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_data_s;
            end else if (S_AXI_RREADY) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = aw_rdy_r;
    assign S_AXI_WREADY  = aw_rdy_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = ar_rdy_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = 2'b00;
    assign irq_o         = irq_r;
endmodule

// File: tb/tb_lpgbt_uplink_capture.sv
// Directed bench for lpgbt_uplink_capture: the stimulus queues expected read data and irq levels,
// and a negedge monitor compares them as the DUT presents read responses.
module tb_lpgbt_uplink_capture;
    localparam int NCH = 2, FW = 234, NW = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0] frame_valid = '0, uplinkrdy = '0, fec = '0;
    logic [NCH*FW-1:0] frame_data = '0;
    logic irq;
    logic [10:0] awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0, rdata;
    logic awvalid = 0, wvalid = 0, arvalid = 0, bready = 1, rready = 1;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0] bresp, rresp;

    lpgbt_uplink_capture dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .frame_valid_i(frame_valid), .frame_data_i(frame_data),
        .uplinkrdy_i(uplinkrdy), .fec_i(fec), .irq_o(irq),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(4'hF), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    logic [31:0] rd_exp_q[$];
    string       rd_nm_q[$];
    logic        irq_exp_q[$];
    string       irq_nm_q[$];
    int          bexp_q[$];
    string       tmo_q[$];
    int errors = 0, checks = 0, bcnt = 0, nwr = 0;

    // Monitor / scoreboard: the only process that counts comparisons
    always @(negedge clk) begin
        if (rvalid) begin
            checks++;
            if (rd_exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read got=%h", rdata);
            end else begin
                logic [31:0] e;
                string n;
                e = rd_exp_q.pop_front();
                n = rd_nm_q.pop_front();
                if (rdata !== e || rresp !== 2'b00) begin
                    errors++;
                    $display("FAIL %s got=%h resp=%0d expected=%h", n, rdata, rresp, e);
                end
            end
        end
        if (bvalid) bcnt++;
        while (irq_exp_q.size() > 0) begin
            logic ei;
            string n;
            ei = irq_exp_q.pop_front();
            n  = irq_nm_q.pop_front();
            checks++;
            if (irq !== ei) begin
                errors++;
                $display("FAIL %s irq=%b expected=%b", n, irq, ei);
            end
        end
        while (bexp_q.size() > 0) begin
            int eb;
            eb = bexp_q.pop_front();
            checks++;
            if (bcnt != eb) begin
                errors++;
                $display("FAIL bvalid_count got=%0d expected=%0d", bcnt, eb);
            end
        end
        while (tmo_q.size() > 0) begin
            string n;
            n = tmo_q.pop_front();
            checks++;
            errors++;
            $display("FAIL timeout %s", n);
        end
    end

    function automatic logic [FW-1:0] fpat(input int n);
        logic [NW*32-1:0] w;
        for (int k = 0; k < NW; k++) w[k*32 +: 32] = 32'hA500_0000 | (32'(n) << 8) | 32'(k);
        return w[FW-1:0];
    endfunction

    function automatic logic [31:0] hw(input int n, input int k);
        logic [31:0] v;
        v = 32'hA500_0000 | (32'(n) << 8) | 32'(k);
        if (k == NW - 1) v = v & 32'h0000_03FF;
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic axi_wr(input logic [10:0] a, input logic [31:0] d, input int aw_lead);
        bit got = 0;
        awaddr = a; wdata = d; awvalid = 1'b1;
        if (aw_lead > 0) idle(aw_lead);
        wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready) begin got = 1; break; end
        end
        if (!got) tmo_q.push_back("axi_wr");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        nwr++;
    endtask

    task automatic axi_rd(input logic [10:0] a, input logic [31:0] e, input string nm);
        bit got = 0;
        rd_exp_q.push_back(e); rd_nm_q.push_back(nm);
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arready) begin got = 1; break; end
        end
        if (!got) tmo_q.push_back(nm);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic chk_irq(input logic e, input string nm);
        irq_exp_q.push_back(e); irq_nm_q.push_back(nm);
    endtask

    task automatic send(input int n, input logic f1, input logic f0);
        frame_data = {fpat(n), ~fpat(n)};
        frame_valid = 2'b11; fec = {f1, f0};
        @(posedge clk); #1;
        frame_valid = 2'b00; fec = 2'b00;
    endtask

    // POP write whose handshake edge coincides with a valid frame
    task automatic pop_with_frame(input int n);
        bit got = 0;
        awaddr = 11'h008; wdata = 32'd0; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready) begin got = 1; break; end
        end
        if (!got) tmo_q.push_back("pop_with_frame");
        frame_data = {fpat(n), ~fpat(n)}; frame_valid = 2'b11;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; frame_valid = 2'b00;
        nwr++;
    endtask

    initial begin
        uplinkrdy = 2'b01;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        // reset state
        axi_rd(11'h004, 32'h0101_0000, "reset_status");
        axi_rd(11'h100, 32'h0, "reset_head0");
        axi_rd(11'h000, 32'h0, "reset_ctrl");
        chk_irq(1'b0, "reset_irq");

        // single-shot on channel 1
        axi_wr(11'h000, 32'h0000_0101, 0);
        axi_rd(11'h004, 32'h0101_0001, "armed_status");
        uplinkrdy = 2'b11;
        idle(2);
        axi_rd(11'h004, 32'h0301_0002, "capture_status");
        for (int n = 0; n <= 16; n++) send(n, 1'b0, 1'b0);
        axi_rd(11'h004, 32'h0302_1003, "ss_full_status");
        chk_irq(1'b1, "ss_done_irq");
        axi_rd(11'h000, 32'h0000_0100, "ctrl_readback");
        for (int k = 0; k < NW; k++) axi_rd(11'h100 + 11'(4*k), hw(0, k), "ss_head_f0");
        axi_wr(11'h008, 32'h0, 0);
        axi_rd(11'h100, hw(1, 0), "pop_head0_f1");
        axi_rd(11'h104, hw(1, 1), "pop_head1_f1");
        axi_rd(11'h004, 32'h0300_0F03, "pop_status");

        // continuous with overflow, then FLUSH
        axi_wr(11'h000, 32'h0000_010B, 0);
        idle(2);
        for (int n = 0; n < 20; n++) send(n, 1'b0, 1'b0);
        axi_rd(11'h004, 32'h0306_1002, "ovf_status");
        chk_irq(1'b1, "ovf_irq");
        axi_rd(11'h100, hw(0, 0), "ovf_head_f0");
        for (int i = 0; i < 15; i++) axi_wr(11'h008, 32'h0, 0);
        axi_rd(11'h100, hw(15, 0), "ovf_tail_f15");
        axi_rd(11'h11C, hw(15, 7), "ovf_tail_f15_w7");
        axi_wr(11'h000, 32'h0000_010A, 0);
        axi_rd(11'h004, 32'h0301_0002, "flush_status");
        chk_irq(1'b0, "flush_irq");
        axi_rd(11'h000, 32'h0000_0102, "flush_ctrl");

        // SKIP_FEC and FEC counters
        axi_wr(11'h000, 32'h0000_0004, 0);
        axi_rd(11'h004, 32'h0301_0000, "stop_status");
        axi_wr(11'h000, 32'h0001_0103, 0);
        idle(2);
        for (int n = 0; n < 10; n++) send(n, 1'(n % 2), 1'b1);
        axi_rd(11'h004, 32'h0300_0502, "skip_status");
        axi_rd(11'h044, 32'd5, "fec_cnt1");
        axi_rd(11'h040, 32'd10, "fec_cnt0");
        axi_rd(11'h100, hw(0, 0), "skip_head_f0");
        axi_rd(11'h104, hw(0, 1), "skip_head_f0_w1");
        axi_wr(11'h044, 32'h1234_5678, 0);
        axi_rd(11'h044, 32'd0, "fec_cnt1_clear");
        axi_rd(11'h040, 32'd10, "fec_cnt0_kept");

        // link loss and STOP+ARM
        uplinkrdy = 2'b01;
        idle(1);
        axi_rd(11'h004, 32'h0108_0501, "lost_status");
        uplinkrdy = 2'b11;
        idle(2);
        axi_rd(11'h004, 32'h0308_0502, "relock_status");
        axi_wr(11'h000, 32'h0000_0105, 0);
        axi_rd(11'h004, 32'h0308_0500, "stop_arm_status");
        axi_rd(11'h000, 32'h0000_0100, "stop_arm_ctrl");

        // full FIFO: POP together with a new frame
        axi_wr(11'h000, 32'h0000_010B, 0);
        idle(2);
        for (int n = 0; n < 16; n++) send(n, 1'b0, 1'b0);
        axi_rd(11'h004, 32'h0302_1002, "refill_status");
        pop_with_frame(16);
        axi_rd(11'h004, 32'h0302_1002, "pop_push_status");
        chk_irq(1'b0, "pop_push_irq");
        axi_rd(11'h100, hw(1, 0), "pop_push_head_f1");
        for (int i = 0; i < 15; i++) axi_wr(11'h008, 32'h0, 0);
        axi_rd(11'h100, hw(16, 0), "pop_push_tail_f16");
        axi_rd(11'h10C, hw(16, 3), "pop_push_tail_f16_w3");
        axi_rd(11'h004, 32'h0300_0102, "drain_status");

        // AW ahead of W, unmapped and out-of-range reads
        axi_wr(11'h040, 32'hFFFF_FFFF, 3);
        axi_rd(11'h040, 32'd0, "aw_lead_clear");
        axi_rd(11'h00C, 32'd0, "unmapped_00c");
        axi_rd(11'h120, 32'd0, "head_oob");
        idle(5);
        bexp_q.push_back(nwr);

        for (int i = 0; i < 100; i++) begin
            if (rd_exp_q.size() == 0 && irq_exp_q.size() == 0 && bexp_q.size() == 0) break;
            idle(1);
        end
        if (rd_exp_q.size() != 0) tmo_q.push_back("drain_reads");
        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lpgbt_uplink_capture.md
Name: lpgbt_uplink_capture

Overview:
- Multi-channel lpGBT uplink frame capture buffer with an AXI4-Lite register interface.
- Monitors NUM_CH decoded uplink user-data streams and selects one channel per capture run.
- Stores up to DEPTH frames in a FIFO; software reads the head frame word by word and pops it.
- Keeps one saturating FEC-correction counter per channel.
- Sits between the lpGBT-FPGA uplink cores (after CDC into the AXI domain) and the PS.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 11, AXI byte-address width.
- NUM_CH, 2, number of uplink channels, 1..8.
- FRAME_WIDTH, 234, user-data bits per frame; NW = ceil(FRAME_WIDTH/32) = 8 words at the default.
- DEPTH, 16, FIFO depth in frames; must be a power of 2, max 128.

Ports:
- S_AXI_ACLK  in  1  single clock; all inputs are synchronous to it.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- frame_valid_i  in  NUM_CH  one-cycle strobe per new frame, per channel.
- frame_data_i  in  NUM_CH*FRAME_WIDTH  channel c occupies bits [c*FRAME_WIDTH +: FRAME_WIDTH].
- uplinkrdy_i  in  NUM_CH  link-ready flag per channel.
- fec_i  in  NUM_CH  FEC-corrected flag; qualified by frame_valid_i.
- irq_o  out  1  high while state is DONE or the OVF sticky bit is set.
- S_AXI_AW*/W*/B*/AR*/R*  standard AXI4-Lite slave, widths per the parameters; AWPROT and ARPROT are ignored.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, CTRL 0, all counters 0, sticky bits 0.
- Register map (byte address):
  - 0x000 CTRL: bit0 ARM (W1P), bit1 MODE (0 = single-shot, 1 = continuous), bit2 STOP (W1P), bit3 FLUSH (W1P), [10:8] CH_SEL, bit16 SKIP_FEC. MODE, CH_SEL and SKIP_FEC read back; W1P bits read 0.
  - 0x004 STATUS (RO): [1:0] state (IDLE=0, ARMED=1, CAPTURE=2, DONE=3), [15:8] level, bit16 empty, bit17 full, bit18 OVF, bit19 LINK_LOST, [31:24] uplinkrdy_i zero-extended.
  - 0x008 POP: any write pops the head frame; ignored when empty.
  - 0x040 + 4c FEC_CNT[c]: 32-bit, saturates at 0xFFFFFFFF; any write clears it. Increments every cycle in which frame_valid_i[c] & fec_i[c], independent of state.
  - 0x100 + 4k HEAD[k], k < NW: head frame bits [32k+31:32k], zero-padded above FRAME_WIDTH; returns 0 when empty.
  - All unmapped addresses read 0, writes are ignored; RESP is always OKAY.
- Capture FSM:
  - CH_SEL, MODE and SKIP_FEC are latched at ARM.
  - IDLE -ARM-> ARMED.
  - ARMED -> CAPTURE on the first cycle uplinkrdy_i[ch] = 1.
  - CAPTURE -> ARMED on uplinkrdy_i[ch] = 0; this sets LINK_LOST.
  - DONE -ARM-> ARMED. ARM is ignored in ARMED and CAPTURE.
  - STOP from any state -> IDLE. STOP has precedence over ARM in the same write.
- Push: in CAPTURE, frame_valid_i[ch] & !(SKIP_FEC & fec_i[ch]) pushes frame_data_i[ch].
  - Level and empty update on the following edge.
  - Push when full: single-shot -> frame dropped, state -> DONE; continuous -> frame dropped, OVF set, stays in CAPTURE.
  - Single-shot also goes -> DONE on the push that makes level = DEPTH.
- Simultaneous push and pop: both take effect and level is unchanged. When full, the pop frees a slot and the push succeeds.
- FLUSH: empties the FIFO and clears OVF and LINK_LOST; state is unchanged. If FLUSH and a push occur in the same cycle, FLUSH wins and the frame is dropped.
- Pointers are log2(DEPTH) bits and wrap; level is log2(DEPTH)+1 bits.
- AXI write:
  - AWREADY and WREADY pulse together for one cycle when AWVALID & WVALID & !BVALID.
  - The register updates on that edge.
  - BVALID rises the next cycle and holds until BREADY.
  - WSTRB is ignored; the full word is written.
- AXI read:
  - ARREADY pulses for one cycle when ARVALID & !RVALID.
  - RDATA is registered; RVALID rises the next cycle and holds until RREADY.
  - A POP and a HEAD read in the same cycle: the read returns the pre-pop head.
- Reset mid-transaction: all channels, including BVALID and RVALID, drop immediately.

Test Plan:
- Reset, then read STATUS -> 0x00010000 | (rdy<<24); HEAD[0] -> 0; irq_o = 0.
- CH_SEL=1, MODE=0, ARM; rdy[1]=1; push 16 frames with incrementing pattern, then a 17th -> level 16, full, state DONE, irq_o = 1. HEAD words match frame 0; after POP, HEAD shows frame 1 and level 15.
- MODE=1, 20 frames into DEPTH=16 -> level 16, OVF = 1, state CAPTURE, frames 0..15 retained. FLUSH -> level 0, OVF = 0.
- SKIP_FEC=1, 10 frames with fec_i on odd frames -> level 5; FEC_CNT[ch] = 5; writing FEC_CNT[ch] reads back 0.
- In CAPTURE, deassert rdy -> state ARMED, LINK_LOST = 1; reassert -> CAPTURE. STOP+ARM in the same write -> IDLE.
- Full FIFO with POP write coinciding with frame_valid -> level stays 16 and the new frame lands at the tail. AW before W by 3 cycles -> single BVALID, one register update.
